// File: rtl/led_event_scheduler.sv
// led_event_scheduler
// Shares one LED_Animation engine between N_REQ event sources. Requests are
// latched into a pending vector and granted round-robin. Each grant fires a
// one-cycle trigger with the winner's index on sel. Further grants are then
// held off for the animation window plus a guard gap, because the engine
// gives no busy/done feedback of its own.
module led_event_scheduler #(
    parameter int N_REQ       = 4,
    parameter int ANIM_CYCLES = 50,
    parameter int GAP_CYCLES  = 2,
    parameter int SEL_W       = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             flush,
    output logic             active,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [N_REQ-1:0] pending
);

    // The counter only ever holds ANIM_CYCLES-1 or GAP_CYCLES-1 at most.
    localparam int CNT_MAX = (ANIM_CYCLES > GAP_CYCLES) ? ANIM_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] ANIM_LOAD = CNT_W'(ANIM_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [SEL_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [SEL_W-1:0]   sel_q,     sel_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               active_q,  active_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic               grant_found;
    logic [SEL_W-1:0]   grant_idx;
    logic [SEL_W-1:0]   scan_idx;
    logic [N_REQ-1:0]   grant_onehot;
    logic [SEL_W-1:0]   grant_next_ptr;

    // Round-robin search: first pending bit at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = SEL_W'((int'(rr_ptr_q) + i) % N_REQ);
            if (!grant_found && pending_q[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        grant_onehot   = grant_found ? (N_REQ'(1) << grant_idx) : '0;
        grant_next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
    end

    // Next-state and registered-output logic; flush overrides everything but sel and rr_ptr.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | req;
        rr_ptr_d  = rr_ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        active_d  = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    pending_d = (pending_q & ~grant_onehot) | req;
                    sel_d     = grant_idx;
                    rr_ptr_d  = grant_next_ptr;
                    active_d  = 1'b1;
                    state_d   = FIRE;
                end
            end
            FIRE: begin
                cnt_d   = ANIM_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            pending_d = '0;
            state_d   = IDLE;
            cnt_d     = '0;
            active_d  = 1'b0;
            done_d    = 1'b0;
            sel_d     = sel_q;
            rr_ptr_d  = rr_ptr_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign active  = active_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_led_event_scheduler.sv
// tb_led_event_scheduler
// Directed stimulus for the round-robin LED event scheduler. Expected
// grants and done pulses are queued by the stimulus thread with their
// hand-computed cycle numbers; a monitor pops and compares them whenever
// the DUT raises active or done.
module tb_led_event_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       active;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [3:0] pending;

    led_event_scheduler #(
        .N_REQ      (4),
        .ANIM_CYCLES(50),
        .GAP_CYCLES (2),
        .SEL_W      (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .flush  (flush),
        .active (active),
        .sel    (sel),
        .busy   (busy),
        .done   (done),
        .pending(pending)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Cycle index: value k is seen at the negedge between edge k and edge k+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] sel;
        int         cyc;
    } grant_t;

    grant_t grantQ[$];
    int     doneQ[$];
    int     checks = 0;
    int     failures = 0;
    int     actCount = 0;
    int     doneCount = 0;
    logic   prevActive = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectGrant(input logic [1:0] s, input int c);
        grant_t g;
        g.sel = s;
        g.cyc = c;
        grantQ.push_back(g);
    endtask

    task automatic expectDone(input int c);
        doneQ.push_back(c);
    endtask

    // Drive req for 'hold' cycles starting at the current negedge, then drop it.
    task automatic applyStimulus(input logic [3:0] v, input int hold);
        req = v;
        repeat (hold) @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare every trigger and done pulse against the queued expectations.
    always @(negedge clk) begin
        if (active) begin
            actCount <= actCount + 1;
            checkOutput("active_not_adjacent", int'(prevActive), 0);
            if (grantQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_active: active=1 sel=%0d in cycle %0d, none expected", sel, cyc);
            end else begin
                grant_t g;
                g = grantQ.pop_front();
                checkOutput("grant_sel", int'(sel), int'(g.sel));
                checkOutput("grant_cycle", cyc, g.cyc);
            end
        end
        if (done) begin
            doneCount <= doneCount + 1;
            if (doneQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: done=1 in cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = doneQ.pop_front();
                checkOutput("done_cycle", cyc, e);
            end
        end
        prevActive <= active;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        checks++;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Directed test sequence.
    initial begin
        int k;
        int k2;
        int busyCycles;
        int actBefore;
        int doneBefore;

        // Reset values
        repeat (4) @(negedge clk);
        checkOutput("reset_active",  int'(active),  0);
        checkOutput("reset_sel",     int'(sel),     0);
        checkOutput("reset_busy",    int'(busy),    0);
        checkOutput("reset_done",    int'(done),    0);
        checkOutput("reset_pending", int'(pending), 0);
        reset = 1'b0;

        // Test 1: single request from source 2
        $display("[TB] test 1: single request");
        k = cyc;
        expectGrant(2'd2, k + 2);
        expectDone(k + 53);
        applyStimulus(4'b0100, 1);
        checkOutput("t1_pending_latched", int'(pending), 4'b0100);
        busyCycles = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy) busyCycles++;
        end
        checkOutput("t1_busy_cycles", busyCycles, 53);
        checkOutput("t1_pending_clear", int'(pending), 0);
        checkOutput("t1_sel_held", int'(sel), 2);

        // Test 2: two simultaneous requests
        $display("[TB] test 2: two requests in one cycle");
        doReset(2);
        k = cyc;
        expectGrant(2'd0, k + 2);
        expectDone(k + 53);
        expectGrant(2'd3, k + 56);
        expectDone(k + 107);
        applyStimulus(4'b1001, 1);
        waitUntil(k + 29);
        checkOutput("t2_pending_between", int'(pending), 4'b1000);
        waitUntil(k + 110);
        checkOutput("t2_pending_clear", int'(pending), 0);
        checkOutput("t2_busy_idle", int'(busy), 0);

        // Test 3: all sources held for 300 cycles, then the latched set drains
        $display("[TB] test 3: continuous load");
        k = cyc;
        for (int i = 0; i < 10; i++) begin
            expectGrant(2'(i % 4), k + 2 + 54 * i);
            expectDone(k + 53 + 54 * i);
        end
        applyStimulus(4'b1111, 300);
        waitUntil(k + 545);
        checkOutput("t3_pending_clear", int'(pending), 0);
        checkOutput("t3_busy_idle", int'(busy), 0);

        // Test 4: re-request of the active source goes behind a waiting one
        $display("[TB] test 4: re-request during own window");
        doReset(2);
        k = cyc;
        expectGrant(2'd1, k + 2);
        expectDone(k + 53);
        expectGrant(2'd2, k + 56);
        expectDone(k + 107);
        expectGrant(2'd1, k + 110);
        expectDone(k + 161);
        applyStimulus(4'b0110, 1);
        waitUntil(k + 10);
        applyStimulus(4'b0010, 1);
        checkOutput("t4_pending_rerequest", int'(pending), 4'b0110);
        waitUntil(k + 170);

        // Test 5: flush in the middle of a window
        $display("[TB] test 5: flush");
        k = cyc;
        expectGrant(2'd0, k + 2);
        applyStimulus(4'b0011, 1);
        waitUntil(k + 22);
        checkOutput("t5_pending_before_flush", int'(pending), 4'b0010);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("t5_busy_after_flush",    int'(busy),    0);
        checkOutput("t5_pending_after_flush", int'(pending), 0);
        checkOutput("t5_active_after_flush",  int'(active),  0);
        checkOutput("t5_sel_kept",            int'(sel),     0);
        actBefore  = actCount;
        doneBefore = doneCount;
        waitUntil(k + 100);
        checkOutput("t5_no_active_after_flush", actCount,  actBefore);
        checkOutput("t5_no_done_after_flush",   doneCount, doneBefore);
        // rr_ptr survived the flush (points at 1), so 2 is served before 0
        k = cyc;
        expectGrant(2'd2, k + 2);
        expectDone(k + 53);
        expectGrant(2'd0, k + 56);
        expectDone(k + 107);
        applyStimulus(4'b0101, 1);
        waitUntil(k + 115);

        // Test 6: reset in the middle of a window
        $display("[TB] test 6: reset mid-animation");
        k = cyc;
        expectGrant(2'd1, k + 2);
        applyStimulus(4'b0010, 1);
        waitUntil(k + 32);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_reset_active",  int'(active),  0);
        checkOutput("t6_reset_sel",     int'(sel),     0);
        checkOutput("t6_reset_busy",    int'(busy),    0);
        checkOutput("t6_reset_done",    int'(done),    0);
        checkOutput("t6_reset_pending", int'(pending), 0);
        reset = 1'b0;
        k2 = cyc;
        expectGrant(2'd0, k2 + 2);
        expectDone(k2 + 53);
        expectGrant(2'd2, k2 + 56);
        expectDone(k2 + 107);
        applyStimulus(4'b0101, 1);
        waitUntil(k2 + 115);

        checkOutput("grant_queue_drained", grantQ.size(), 0);
        checkOutput("done_queue_drained",  doneQ.size(),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
